// File: rtl/seg7_capture.sv
// Loopback monitor for a multiplexed active-low 7-segment link: waits for a stable
// one-digit pattern, decodes it and keeps per-digit value/blank/valid registers.
// Optional per-digit staleness timeout is enabled with `define SEG7CAP_TIMEOUT_EN.
module seg7_capture #(
  parameter int NDIG    = 8,
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NDIG-1:0]         an_n,
  output logic [3*NDIG-1:0]       digit_val,
  output logic [NDIG-1:0]         digit_blank,
  output logic [NDIG-1:0]         digit_valid,
  output logic                    err_pulse,
  output logic [$clog2(NDIG)-1:0] err_digit,
  output logic                    frame_done
);

  localparam int IW = $clog2(NDIG);
  localparam int SW = NDIG + 7;
  localparam int CW = 8;

  if (NDIG < 2 || NDIG > 16 || STABLE < 2 || STABLE > 255 || TIMEOUT < 1) begin : g_bad_param
    $error("seg7_capture: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURED
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3*NDIG-1:0]   val_q, val_d;
  logic [NDIG-1:0]     blank_q, blank_d;
  logic [NDIG-1:0]     valid_q, valid_d;
  logic [NDIG-1:0]     seen_q, seen_d;
  logic                err_q, err_d;
  logic [IW-1:0]       err_dig_q, err_dig_d;
  logic                frame_q, frame_d;

`ifdef SEG7CAP_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT + 1);
  logic [AW-1:0] age_q [NDIG];
  logic [AW-1:0] age_d [NDIG];
`endif

  logic [NDIG-1:0] sel_n;
  logic [6:0]      pat;
  logic [IW:0]     nsel;
  logic [IW-1:0]   sel_idx;
  logic            onehot;
  logic [2:0]      dec_val;
  logic            is_num;
  logic            is_blank;
  logic            capture;

  assign sel_n  = s_q[SW-1:7];
  assign pat    = ~s_q[6:0];
  assign onehot = (nsel == (IW+1)'(1));

  always_comb begin
    nsel    = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (!sel_n[i]) begin
        nsel    = nsel + 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  always_comb begin
    dec_val  = '0;
    is_num   = 1'b1;
    is_blank = 1'b0;
    case (pat)
      7'b111_1110: dec_val = 3'd0;
      7'b011_0000: dec_val = 3'd1;
      7'b110_1101: dec_val = 3'd2;
      7'b111_1001: dec_val = 3'd3;
      7'b011_0011: dec_val = 3'd4;
      7'b101_1011: dec_val = 3'd5;
      7'b101_1111: dec_val = 3'd6;
      7'b111_0000: dec_val = 3'd7;
      7'b000_0000: begin
        is_num   = 1'b0;
        is_blank = 1'b1;
      end
      default: is_num = 1'b0;
    endcase
  end

  // cnt_q == 0 marks the first cycle of a new sample, which is how CAPTURED
  // notices that s changed without keeping a second copy of the sample.
  always_comb begin
    s_d     = {an_n, seg_n};
    cnt_d   = (s_d != s_q) ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: if (onehot) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!onehot) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(STABLE - 1)) begin
          capture = 1'b1;
          state_d = ST_CAPTURED;
        end
      end
      ST_CAPTURED: if (cnt_q == '0) state_d = onehot ? ST_SETTLE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    val_d     = val_q;
    blank_d   = blank_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    err_d     = 1'b0;
    err_dig_d = err_dig_q;
    frame_d   = 1'b0;
`ifdef SEG7CAP_TIMEOUT_EN
    for (int unsigned i = 0; i < NDIG; i++) begin
      age_d[i] = (age_q[i] == AW'(TIMEOUT)) ? age_q[i] : age_q[i] + 1'b1;
      if (age_d[i] == AW'(TIMEOUT)) valid_d[i] = 1'b0;
    end
`endif
    // Capture is applied after the timeout so it wins on the same digit.
    if (capture) begin
      seen_d[sel_idx] = 1'b1;
`ifdef SEG7CAP_TIMEOUT_EN
      age_d[sel_idx] = '0;
`endif
      if (is_num) begin
        val_d[int'(sel_idx)*3 +: 3] = dec_val;
        blank_d[sel_idx]            = 1'b0;
        valid_d[sel_idx]            = 1'b1;
      end else if (is_blank) begin
        blank_d[sel_idx] = 1'b1;
        valid_d[sel_idx] = 1'b1;
      end else begin
        valid_d[sel_idx] = 1'b0;
        err_d            = 1'b1;
        err_dig_d        = sel_idx;
      end
    end
    if (&seen_d) begin
      frame_d = 1'b1;
      seen_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s_q       <= '1;
      cnt_q     <= '0;
      val_q     <= '0;
      blank_q   <= '0;
      valid_q   <= '0;
      seen_q    <= '0;
      err_q     <= 1'b0;
      err_dig_q <= '0;
      frame_q   <= 1'b0;
`ifdef SEG7CAP_TIMEOUT_EN
      age_q     <= '{default: '0};
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      val_q     <= val_d;
      blank_q   <= blank_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
      err_dig_q <= err_dig_d;
      frame_q   <= frame_d;
`ifdef SEG7CAP_TIMEOUT_EN
      age_q     <= age_d;
`endif
    end
  end

  assign digit_val   = val_q;
  assign digit_blank = blank_q;
  assign digit_valid = valid_q;
  assign err_pulse   = err_q;
  assign err_digit   = err_dig_q;
  assign frame_done  = frame_q;

endmodule
